// File: rtl/instruction_fetch_stage_if.sv
// rtl/instruction_fetch_stage_if.sv - fetch stage bus: imem port, decode control, IF/ID outputs
// master = fetch stage, slave = memory/decode side.
interface instruction_fetch_stage_if;
  logic [31:0] imem_address;
  logic [31:0] imem_instruction;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] if_id_instruction;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc_plus4;
  logic        if_id_valid;
  logic        halted;
  logic        fetch_fault;

  modport master (
    output imem_address,
    input  imem_instruction,
    input  stall,
    input  redirect_valid,
    input  redirect_pc,
    output if_id_instruction,
    output if_id_pc,
    output if_id_pc_plus4,
    output if_id_valid,
    output halted,
    output fetch_fault
  );

  modport slave (
    input  imem_address,
    output imem_instruction,
    output stall,
    output redirect_valid,
    output redirect_pc,
    input  if_id_instruction,
    input  if_id_pc,
    input  if_id_pc_plus4,
    input  if_id_valid,
    input  halted,
    input  fetch_fault
  );
endinterface

// File: rtl/instruction_fetch_stage.sv
// rtl/instruction_fetch_stage.sv - PC owner, IF/ID register, BOOT/RUN/HALT fetch FSM
// Optional alignment/range fault checking enabled by defining FETCH_ALIGN_CHECK_EN.
module instruction_fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_BYTES = 1024,
  parameter logic [31:0] HALT_WORD  = 32'hFFFF_FFFF
) (
  input logic                        i_clk,
  input logic                        i_reset,
  instruction_fetch_stage_if.master  bus
);

  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  localparam logic [31:0] LAST_WORD_ADDR = 32'(IMEM_BYTES - 4);

`ifdef FETCH_ALIGN_CHECK_EN
  localparam logic CHECK_EN = 1'b1;
`else
  localparam logic CHECK_EN = 1'b0;
`endif

  logic [1:0]  r_state;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_if_pc;
  logic [31:0] r_if_pc_plus4;
  logic        r_valid;
  logic        r_fault;

  logic [31:0] w_pc_plus4;
  logic        w_is_halt_word;
  logic        w_redirect_bad;
  logic        w_range_bad;

  assign w_pc_plus4     = r_pc + 32'd4;
  assign w_is_halt_word = (bus.imem_instruction == HALT_WORD);
  // With checking compiled out these collapse to constant 0.
  assign w_redirect_bad = CHECK_EN & (bus.redirect_pc[1:0] != 2'b00);
  assign w_range_bad    = CHECK_EN & (r_pc > LAST_WORD_ADDR);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= ST_BOOT;
      r_pc          <= RESET_PC;
      r_instr       <= 32'd0;
      r_if_pc       <= 32'd0;
      r_if_pc_plus4 <= 32'd0;
      r_valid       <= 1'b0;
      r_fault       <= 1'b0;
    end else begin
      case (r_state)
        ST_BOOT: begin
          r_state <= ST_RUN;
          if (bus.redirect_valid) begin
            r_pc <= bus.redirect_pc;
            if (w_redirect_bad) begin
              r_fault <= 1'b1;
              r_state <= ST_HALT;
            end
          end
        end
        ST_RUN: begin
          if (bus.redirect_valid) begin
            r_pc    <= bus.redirect_pc;
            r_valid <= 1'b0;
            if (w_redirect_bad) begin
              r_fault <= 1'b1;
              r_state <= ST_HALT;
            end
          end else if (bus.stall) begin
            r_pc <= r_pc;
          end else if (w_range_bad) begin
            r_fault <= 1'b1;
            r_valid <= 1'b0;
            r_state <= ST_HALT;
          end else begin
            r_instr       <= bus.imem_instruction;
            r_if_pc       <= r_pc;
            r_if_pc_plus4 <= w_pc_plus4;
            r_valid       <= 1'b1;
            r_pc          <= w_pc_plus4;
            if (w_is_halt_word) begin
              r_state <= ST_HALT;
            end
          end
        end
        ST_HALT: begin
          r_valid <= 1'b0;
          // A latched fault pins the stage here until reset.
          if (bus.redirect_valid && !r_fault) begin
            r_pc <= bus.redirect_pc;
            if (w_redirect_bad) begin
              r_fault <= 1'b1;
            end else begin
              r_state <= ST_RUN;
            end
          end
        end
        default: r_state <= ST_BOOT;
      endcase
    end
  end

  assign bus.imem_address      = r_pc;
  assign bus.if_id_instruction = r_instr;
  assign bus.if_id_pc          = r_if_pc;
  assign bus.if_id_pc_plus4    = r_if_pc_plus4;
  assign bus.if_id_valid       = r_valid;
  assign bus.halted            = (r_state == ST_HALT);
  assign bus.fetch_fault       = r_fault;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// tb/tb_instruction_fetch_stage.sv - table-driven scoreboard bench for instruction_fetch_stage
// Fault sequences are compiled in only when FETCH_ALIGN_CHECK_EN is defined.
module tb_instruction_fetch_stage;

  localparam logic [31:0] W_A    = 32'h0000_0013;
  localparam logic [31:0] W_B    = 32'h0010_0093;
  localparam logic [31:0] W_C    = 32'h0020_0113;
  localparam logic [31:0] W_D    = 32'h0030_0193;
  localparam logic [31:0] W_40   = 32'hDEAD_BEEF;
  localparam logic [31:0] W_HALT = 32'hFFFF_FFFF;

  typedef struct {
    logic [31:0] pc;
    logic        valid;
    logic [31:0] if_pc;
    logic [31:0] instr;
    logic        halted;
    logic        fault;
  } exp_t;

  typedef struct {
    logic        stall;
    logic        rv;
    logic [31:0] rpc;
    exp_t        e;
  } vec_t;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  exp_t sb[$];
  vec_t vecs[$];

  instruction_fetch_stage_if bus ();

  instruction_fetch_stage dut (
    .i_clk   (clk),
    .i_reset (reset),
    .bus     (bus)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h00:  return W_A;
      32'h04:  return W_B;
      32'h08:  return W_C;
      32'h0C:  return W_D;
      32'h10:  return W_HALT;
      32'h40:  return W_40;
      default: return a ^ 32'hA5A5_0000;
    endcase
  endfunction

  assign bus.imem_instruction = mem_word(bus.imem_address);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s act=%h req=%h", name, act, req);
    end
  endtask

  function automatic vec_t v(input logic s, input logic r, input logic [31:0] rp,
                             input logic [31:0] pc, input logic val, input logic [31:0] ifpc,
                             input logic [31:0] ins, input logic h, input logic f);
    vec_t x;
    x.stall = s; x.rv = r; x.rpc = rp;
    x.e.pc = pc; x.e.valid = val; x.e.if_pc = ifpc; x.e.instr = ins;
    x.e.halted = h; x.e.fault = f;
    return x;
  endfunction

  task automatic step(input string tag, input vec_t x);
    exp_t e;
    bus.stall          = x.stall;
    bus.redirect_valid = x.rv;
    bus.redirect_pc    = x.rpc;
    sb.push_back(x.e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({tag, ".pc"},     bus.imem_address,            e.pc);
    chk({tag, ".valid"},  32'(bus.if_id_valid),        32'(e.valid));
    chk({tag, ".if_pc"},  bus.if_id_pc,                e.if_pc);
    chk({tag, ".instr"},  bus.if_id_instruction,       e.instr);
    chk({tag, ".halted"}, 32'(bus.halted),             32'(e.halted));
    chk({tag, ".fault"},  32'(bus.fetch_fault),        32'(e.fault));
    if (e.valid) chk({tag, ".plus4"}, bus.if_id_pc_plus4, e.if_pc + 32'd4);
    bus.stall          = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'd0;
  endtask

  task automatic do_reset();
    reset              = 1'b1;
    bus.stall          = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'd0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    do_reset();
    chk("rst.pc",     bus.imem_address,            32'h0);
    chk("rst.valid",  32'(bus.if_id_valid),        32'h0);
    chk("rst.if_pc",  bus.if_id_pc,                32'h0);
    chk("rst.plus4",  bus.if_id_pc_plus4,          32'h0);
    chk("rst.instr",  bus.if_id_instruction,       32'h0);
    chk("rst.halted", 32'(bus.halted),             32'h0);
    chk("rst.fault",  32'(bus.fetch_fault),        32'h0);

    vecs.push_back(v(0, 0, 32'h0,  32'h0,  0, 32'h0,  32'h0,  0, 0));
    vecs.push_back(v(0, 0, 32'h0,  32'h4,  1, 32'h0,  W_A,    0, 0));
    vecs.push_back(v(0, 0, 32'h0,  32'h8,  1, 32'h4,  W_B,    0, 0));
    vecs.push_back(v(1, 0, 32'h0,  32'h8,  1, 32'h4,  W_B,    0, 0));
    vecs.push_back(v(1, 0, 32'h0,  32'h8,  1, 32'h4,  W_B,    0, 0));
    vecs.push_back(v(0, 0, 32'h0,  32'hC,  1, 32'h8,  W_C,    0, 0));
    vecs.push_back(v(1, 1, 32'h40, 32'h40, 0, 32'h8,  W_C,    0, 0));
    vecs.push_back(v(0, 0, 32'h0,  32'h44, 1, 32'h40, W_40,   0, 0));
    vecs.push_back(v(0, 1, 32'h10, 32'h10, 0, 32'h40, W_40,   0, 0));
    vecs.push_back(v(0, 0, 32'h0,  32'h14, 1, 32'h10, W_HALT, 1, 0));
    vecs.push_back(v(1, 0, 32'h0,  32'h14, 0, 32'h10, W_HALT, 1, 0));
    vecs.push_back(v(0, 0, 32'h0,  32'h14, 0, 32'h10, W_HALT, 1, 0));
    vecs.push_back(v(0, 0, 32'h0,  32'h14, 0, 32'h10, W_HALT, 1, 0));
    vecs.push_back(v(0, 0, 32'h0,  32'h14, 0, 32'h10, W_HALT, 1, 0));
    vecs.push_back(v(0, 1, 32'h0,  32'h0,  0, 32'h10, W_HALT, 0, 0));
    vecs.push_back(v(0, 0, 32'h0,  32'h4,  1, 32'h0,  W_A,    0, 0));
`ifndef FETCH_ALIGN_CHECK_EN
    vecs.push_back(v(0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 0, 32'h0, W_A, 0, 0));
    vecs.push_back(v(0, 0, 32'h0, 32'h0, 1, 32'hFFFF_FFFC, 32'h5A5A_FFFC, 0, 0));
    vecs.push_back(v(0, 1, 32'h22, 32'h22, 0, 32'hFFFF_FFFC, 32'h5A5A_FFFC, 0, 0));
`endif
    for (int i = 0; i < vecs.size(); i++) begin
      step($sformatf("v%0d", i), vecs[i]);
    end

    // Redirect during BOOT, together with stall.
    do_reset();
    step("boot_redir", v(1, 1, 32'h40, 32'h40, 0, 32'h0,  32'h0, 0, 0));
    step("boot_next",  v(0, 0, 32'h0,  32'h44, 1, 32'h40, W_40,  0, 0));

    // Reset beats a simultaneous redirect.
    reset              = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h80;
    @(posedge clk);
    #1;
    chk("rst_ovr.pc",    bus.imem_address,     32'h0);
    chk("rst_ovr.valid", 32'(bus.if_id_valid), 32'h0);
    chk("rst_ovr.if_pc", bus.if_id_pc,         32'h0);
    reset              = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'd0;

`ifdef FETCH_ALIGN_CHECK_EN
    do_reset();
    step("f_boot",  v(0, 0, 32'h0,  32'h0,  0, 32'h0, 32'h0, 0, 0));
    step("f_mis",   v(0, 1, 32'h22, 32'h22, 0, 32'h0, 32'h0, 1, 1));
    step("f_stuck", v(0, 1, 32'h0,  32'h22, 0, 32'h0, 32'h0, 1, 1));
    do_reset();
    chk("f_clr.fault",  32'(bus.fetch_fault), 32'h0);
    chk("f_clr.halted", 32'(bus.halted),      32'h0);
    step("r_boot",  v(0, 1, 32'h3FC, 32'h3FC, 0, 32'h0,   32'h0,         0, 0));
    step("r_last",  v(0, 0, 32'h0,   32'h400, 1, 32'h3FC, 32'hA5A5_03FC, 0, 0));
    step("r_over",  v(0, 0, 32'h0,   32'h400, 0, 32'h3FC, 32'hA5A5_03FC, 1, 1));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
